// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: default line settings, receiver/transmitter state
// encoding and the bit-period helper used by uart_rx and uart_tx.
package uart_rx_pkg;

  localparam int UART_CLK_FREQ = 100_000_000;
  localparam int UART_BAUD     = 9600;
  localparam int BAUD_CNT_W    = 27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Whole clocks per serial bit (truncating).
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Clearable bit-timing counter. In half-bit mode it fires half_tick after
// HALF_BIT clocks (centre of the start bit); in full-bit mode it fires
// bit_tick every CLKS_PER_BIT clocks. The counter wraps on its own tick, so
// the next interval starts without any help from the caller.
module uart_baud_gen
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int HALF_BIT     = 5208
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  full_bit,
  output logic                  half_tick,
  output logic                  bit_tick,
  output logic [BAUD_CNT_W-1:0] cnt
);

  localparam logic [BAUD_CNT_W-1:0] FULL_LAST = BAUD_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(HALF_BIT - 1);

  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BAUD_CNT_W-1:0] cnt_d;

  // Tick decode and next counter value: hold at zero while cleared, wrap on a tick.
  always_comb begin
    half_tick = !clr && !full_bit && (cnt_q == HALF_LAST);
    bit_tick  = !clr &&  full_bit && (cnt_q == FULL_LAST);
    cnt_d     = cnt_q + BAUD_CNT_W'(1);
    if (clr || half_tick || bit_tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver. The rx pin is synchronised, the start bit is
// confirmed at its centre, data bits are sampled at their centres LSB-first,
// and a good stop bit publishes the word with a one-cycle rx_valid strobe.
// A low stop bit is a framing error: the word is dropped and the receiver
// waits for the line to return high before arming again.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = UART_CLK_FREQ,
  parameter int BAUD       = UART_BAUD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rx_valid,
  output logic                  internal_baud_test,
  output logic [BAUD_CNT_W-1:0] baud_counter_test,
  output logic [DATA_WIDTH-1:0] data_rx_test,
  output logic [3:0]            data_counter_test
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  logic [1:0]            sync_q, sync_d;
  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;

  logic                  rx_s;
  logic                  baud_clr;
  logic                  baud_full;
  logic                  half_tick;
  logic                  bit_tick;
  logic [BAUD_CNT_W-1:0] baud_cnt;

  assign rx_s = sync_q[1];

  // Counter idles at zero outside a frame and while waiting out a framing error;
  // derived from registered state only so the tick decode has no loop.
  assign baud_clr  = (state_q == IDLE) || ((state_q == STOP) && err_q);
  assign baud_full = (state_q == DATA) || (state_q == STOP);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF_BIT     (HALF_BIT)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (baud_clr),
    .full_bit  (baud_full),
    .half_tick (half_tick),
    .bit_tick  (bit_tick),
    .cnt       (baud_cnt)
  );

  // Two-stage synchroniser for the asynchronous rx pin.
  always_comb begin
    sync_d = {sync_q[0], rx};
  end

  // Frame FSM, shift register and output word: next-state logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (half_tick) begin
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d                 = shift_q >> 1;
          shift_d[DATA_WIDTH-1]   = rx_s;
          bit_cnt_d               = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (err_q) begin
          if (rx_s) begin
            err_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (bit_tick) begin
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; everything aborts on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign data_out           = data_q;
  assign rx_valid           = valid_q;
  assign internal_baud_test = bit_tick;
  assign baud_counter_test  = baud_cnt;
  assign data_rx_test       = shift_q;
  assign data_counter_test  = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are driven bit by bit, good frames are
// queued as expected words, and each rx_valid strobe pops and compares.
// A faster baud rate is used so the whole run stays short.
module tb_uart_rx;

  localparam int DATA_WIDTH = 8;
  localparam int CLK_FREQ   = 100_000_000;
  localparam int BAUD       = 1_000_000;
  localparam int CPB        = CLK_FREQ / BAUD;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  rx  = 1'b1;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rx_valid;
  logic                  internal_baud_test;
  logic [26:0]           baud_counter_test;
  logic [DATA_WIDTH-1:0] data_rx_test;
  logic [3:0]            data_counter_test;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rx                 (rx),
    .data_out           (data_out),
    .rx_valid           (rx_valid),
    .internal_baud_test (internal_baud_test),
    .baud_counter_test  (baud_counter_test),
    .data_rx_test       (data_rx_test),
    .data_counter_test  (data_counter_test)
  );

  int             n_checks  = 0;
  int             n_fail    = 0;
  int             n_pushed  = 0;
  int             n_strobes = 0;
  int             cyc       = 0;
  int             last_tick = -1;
  int             max_cnt   = 0;
  logic [7:0]     exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clks(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit good);
    if (good) begin
      exp_q.push_back(d);
      n_pushed++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < DATA_WIDTH; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
    rx = 1'b1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard, tick period and counter range monitor.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_valid) begin
        n_strobes++;
        check_val("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check_val("data_out", 32'(data_out), 32'(e));
          check_val("data_cnt_at_strobe", 32'(data_counter_test), 32'(DATA_WIDTH));
        end
      end
      if (internal_baud_test) begin
        if (last_tick >= 0 && (cyc - last_tick) < (3 * CPB) / 2)
          check_val("tick_period", 32'(cyc - last_tick), 32'(CPB));
        last_tick = cyc;
      end
      if (int'(baud_counter_test) > max_cnt) max_cnt = int'(baud_counter_test);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] abort_byte;
    abort_byte = 8'hEE;

    // Reset state
    #100;
    check_val("rst_data_out", 32'(data_out), 32'h0);
    check_val("rst_rx_valid", 32'(rx_valid), 32'h0);
    check_val("rst_tick", 32'(internal_baud_test), 32'h0);
    check_val("rst_baud_cnt", 32'(baud_counter_test), 32'h0);
    check_val("rst_shift", 32'(data_rx_test), 32'h0);
    check_val("rst_bit_cnt", 32'(data_counter_test), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_clks(10);

    // Single frame then two back-to-back frames
    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_clks(CPB);
    check_val("strobes_after_3", 32'(n_strobes), 32'd3);
    check_val("data_after_3", 32'(data_out), 32'hFF);

    // Short glitch in idle
    rx = 1'b0;
    wait_clks(20);
    rx = 1'b1;
    wait_clks(2 * CPB);
    check_val("glitch_strobes", 32'(n_strobes), 32'd3);
    check_val("glitch_data", 32'(data_out), 32'hFF);
    check_val("glitch_idle_cnt", 32'(baud_counter_test), 32'h0);

    // Framing error then a good frame
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_clks(2 * CPB);
    check_val("ferr_strobes", 32'(n_strobes), 32'd3);
    check_val("ferr_data", 32'(data_out), 32'hFF);
    check_val("ferr_shift", 32'(data_rx_test), 32'h3C);
    check_val("ferr_idle_cnt", 32'(baud_counter_test), 32'h0);
    send_frame(8'h5A, 1'b1, 1'b1);
    wait_clks(CPB);
    check_val("after_ferr_data", 32'(data_out), 32'h5A);
    check_val("after_ferr_strobes", 32'(n_strobes), 32'd4);

    // Reset in the middle of data bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
    rx = abort_byte[4];
    wait_clks(CPB / 2);
    rst = 1'b0;
    #1;
    check_val("abort_data_out", 32'(data_out), 32'h0);
    check_val("abort_rx_valid", 32'(rx_valid), 32'h0);
    check_val("abort_tick", 32'(internal_baud_test), 32'h0);
    check_val("abort_baud_cnt", 32'(baud_counter_test), 32'h0);
    check_val("abort_shift", 32'(data_rx_test), 32'h0);
    check_val("abort_bit_cnt", 32'(data_counter_test), 32'h0);
    wait_clks(5);
    rx = 1'b1;
    wait_clks(5);
    rst = 1'b1;
    wait_clks(CPB);
    send_frame(8'hC3, 1'b1, 1'b1);
    wait_clks(2 * CPB);
    check_val("post_abort_data", 32'(data_out), 32'hC3);
    check_val("total_strobes", 32'(n_strobes), 32'd5);
    check_val("strobes_vs_pushed", 32'(n_strobes), 32'(n_pushed));
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    check_val("baud_cnt_max", 32'(max_cnt), 32'(CPB - 1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
